btn_debounce_multi: RTL and testbench

- Multi-channel successor to the single-button debouncer: N_CH independent channels, each with a 2-FF synchroniser, debounce filter, edge pulses and a press-and-hold detector (long-press pulse plus optional auto-repeat).
- All timing derives from one shared 1 ms tick, so per-channel counters are narrow.
- Sits between the board pushbuttons and the menu/game FSMs, replacing per-button debounce instances.

---
 rtl/btn_pkg.sv | 26 ++
 rtl/ms_tick_gen.sv | 30 +++
 rtl/btn_debounce_multi.sv | 138 +++++++++++++
 tb/tb_btn_debounce_multi.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and elaboration helpers for the button debounce blocks.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } hold_state_t;

    // Width needed to hold v distinct values; never narrower than 1 bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int tick_div(input int clk_freq);
        return clk_freq / 1000;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// One-cycle 1 ms tick derived from the system clock.
module ms_tick_gen
    import btn_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = tick_div(CLK_FREQ);
    localparam int W   = clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel button debouncer with edge pulses, long-press and auto-repeat.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int N_CH        = 5,
    parameter int CLK_FREQ    = 100_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int REPEAT_EN   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_long,
    output logic [N_CH-1:0] btn_repeat
);

    localparam int DBW = clog2(DEBOUNCE_MS + 1);
    localparam int HCW = clog2(max_i(LONG_MS, REPEAT_MS));
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_MS - 1);
    localparam logic [HCW-1:0] LONG_LAST = HCW'(LONG_MS - 1);
    localparam logic [HCW-1:0] REP_LAST  = HCW'(REPEAT_MS - 1);

    logic tick;

    ms_tick_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]     sync_q;
        logic           stable;
        logic [DBW-1:0] db_cnt;
        logic           rise_q;
        logic           fall_q;
        logic           long_q;
        logic           rep_q;
        logic [HCW-1:0] hold_cnt;
        hold_state_t    state;
        logic           accept;

        assign accept = tick && (sync_q[1] != stable) && (db_cnt == DB_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[0], btn_in[i]};
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stable <= 1'b0;
                db_cnt <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= accept && sync_q[1];
                fall_q <= accept && !sync_q[1];
                if (sync_q[1] == stable) begin
                    db_cnt <= '0;
                end else if (accept) begin
                    stable <= sync_q[1];
                    db_cnt <= '0;
                end else if (tick) begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        // A release always wins over a long/repeat expiry on the same tick.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= IDLE;
                hold_cnt <= '0;
                long_q   <= 1'b0;
                rep_q    <= 1'b0;
            end else begin
                long_q <= 1'b0;
                rep_q  <= 1'b0;
                if (accept && !sync_q[1]) begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end else begin
                    unique case (state)
                        IDLE: begin
                            if (accept && sync_q[1]) begin
                                state    <= HELD;
                                hold_cnt <= '0;
                            end
                        end
                        HELD: begin
                            if (tick) begin
                                if (hold_cnt == LONG_LAST) begin
                                    long_q   <= 1'b1;
                                    hold_cnt <= '0;
                                    state    <= LONG;
                                end else begin
                                    hold_cnt <= hold_cnt + 1'b1;
                                end
                            end
                        end
                        LONG: begin
                            if (REPEAT_EN != 0 && tick) begin
                                if (hold_cnt == REP_LAST) begin
                                    rep_q    <= 1'b1;
                                    hold_cnt <= '0;
                                end else begin
                                    hold_cnt <= hold_cnt + 1'b1;
                                end
                            end
                        end
                        default: begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign btn_level[i]  = stable;
        assign btn_rise[i]   = rise_q;
        assign btn_fall[i]   = fall_q;
        assign btn_long[i]   = long_q;
        assign btn_repeat[i] = rep_q;
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: directed scenarios plus random dwell stimulus.
module tb_btn_debounce_multi;

    localparam int N  = 3;
    localparam int CF = 10_000;
    localparam int TD = 10;
    localparam int DB = 3;
    localparam int LG = 10;
    localparam int RP = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_in;
    logic [N-1:0] lvl, rise, fall, lng, rep;
    logic [N-1:0] lvl2, rise2, fall2, lng2, rep2;

    btn_debounce_multi #(
        .N_CH(N), .CLK_FREQ(CF), .DEBOUNCE_MS(DB),
        .LONG_MS(LG), .REPEAT_MS(RP), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(lvl), .btn_rise(rise), .btn_fall(fall),
        .btn_long(lng), .btn_repeat(rep)
    );

    btn_debounce_multi #(
        .N_CH(N), .CLK_FREQ(CF), .DEBOUNCE_MS(DB),
        .LONG_MS(LG), .REPEAT_MS(RP), .REPEAT_EN(0)
    ) dut_norep (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(lvl2), .btn_rise(rise2), .btn_fall(fall2),
        .btn_long(lng2), .btn_repeat(rep2)
    );

    always #5 clk = ~clk;

    // Reference: ticks come from a free cycle count; hold timing is
    // "ticks elapsed since the accepted press".
    logic [N-1:0] m_s1, m_s2;
    logic [N-1:0] e_lvl, e_rise, e_fall, e_lng, e_rep;
    int           m_run [N];
    int           m_ticks [N];
    logic [N-1:0] m_held;
    int           m_tcnt;
    logic         tk, sv, nlev, ar, af, nheld, lo, re;
    int           nrun, nt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1   <= '0;
            m_s2   <= '0;
            e_lvl  <= '0;
            e_rise <= '0;
            e_fall <= '0;
            e_lng  <= '0;
            e_rep  <= '0;
            m_held <= '0;
            m_tcnt <= 0;
            for (int c = 0; c < N; c++) begin
                m_run[c]   <= 0;
                m_ticks[c] <= 0;
            end
        end else begin
            tk = (m_tcnt == TD - 1);
            m_tcnt <= (m_tcnt + 1) % TD;
            m_s1 <= btn_in;
            m_s2 <= m_s1;
            for (int c = 0; c < N; c++) begin
                sv   = m_s2[c];
                nrun = m_run[c];
                nlev = e_lvl[c];
                ar   = 1'b0;
                af   = 1'b0;
                if (sv != e_lvl[c]) begin
                    if (tk) begin
                        nrun = nrun + 1;
                        if (nrun == DB) begin
                            nlev = sv;
                            nrun = 0;
                            ar   = sv;
                            af   = !sv;
                        end
                    end
                end else begin
                    nrun = 0;
                end
                nheld = m_held[c];
                nt    = m_ticks[c];
                lo    = 1'b0;
                re    = 1'b0;
                if (ar) begin
                    nheld = 1'b1;
                    nt    = 0;
                end else if (af) begin
                    nheld = 1'b0;
                    nt    = 0;
                end else if (nheld && tk) begin
                    nt = nt + 1;
                    lo = (nt == LG);
                    re = (nt > LG) && ((nt - LG) % RP == 0);
                end
                m_run[c]   <= nrun;
                m_ticks[c] <= nt;
                m_held[c]  <= nheld;
                e_lvl[c]   <= nlev;
                e_rise[c]  <= ar;
                e_fall[c]  <= af;
                e_lng[c]   <= lo;
                e_rep[c]   <= re;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [N-1:0] obs,
                         input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b cyc=%0d",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic check_rng(input string tag, input int got,
                             input int lo_v, input int hi_v);
        checks++;
        assert (got >= lo_v && got <= hi_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d",
                   tag, got, lo_v, hi_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check("level", lvl, e_lvl);
        check("rise", rise, e_rise);
        check("fall", fall, e_fall);
        check("long", lng, e_lng);
        check("repeat", rep, e_rep);
        check("level_nr", lvl2, e_lvl);
        check("rise_nr", rise2, e_rise);
        check("fall_nr", fall2, e_fall);
        check("long_nr", lng2, e_lng);
        check("repeat_nr", rep2, '0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // kind: 0 rise, 1 fall, 2 long, 3 repeat; at=-1 if budget expires
    task automatic wait_bit(input int ch, input int kind,
                            input int budget, output int at);
        logic [N-1:0] v;
        at = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            v = (kind == 0) ? rise : (kind == 1) ? fall :
                (kind == 2) ? lng : rep;
            if (v[ch]) begin
                at = cyc;
                break;
            end
        end
    endtask

    int t0, at, at2, seen;
    int dwell [N];

    initial begin
        rst_n  = 1'b0;
        btn_in = '0;
        run(3);
        check("reset_level", lvl, '0);
        check("reset_rise", rise, '0);
        rst_n = 1'b1;
        run(20);

        // Clean press, long, repeats, release.
        btn_in[0] = 1'b1;
        t0 = cyc;
        wait_bit(0, 0, 40, at);
        check_rng("press_latency", at - t0, 22, 32);
        check("press_level", lvl, 3'b001);
        wait_bit(0, 2, 150, at2);
        check_rng("long_delay", at2 - at, 100, 100);
        wait_bit(0, 3, 60, at);
        check_rng("repeat1_delay", at - at2, 40, 40);
        wait_bit(0, 3, 60, at2);
        check_rng("repeat2_delay", at2 - at, 40, 40);
        btn_in[0] = 1'b0;
        t0 = cyc;
        wait_bit(0, 1, 40, at);
        check_rng("release_latency", at - t0, 22, 32);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (rep != 0) seen++;
        end
        check_rng("no_repeat_after_release", seen, 0, 0);

        // Bounce on channel 1: never held long enough to accept.
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (k % 7 == 0) btn_in[1] = ~btn_in[1];
            step();
            if (rise[1] || fall[1] || lvl[1]) seen++;
        end
        btn_in[1] = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (rise[1] || fall[1] || lvl[1]) seen++;
        end
        check_rng("bounce_quiet", seen, 0, 0);

        // Short press on channel 2.
        btn_in[2] = 1'b1;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (lng[2]) seen++;
        end
        btn_in[2] = 1'b0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (lng[2]) seen++;
        end
        check_rng("short_no_long", seen, 0, 0);
        check("short_level", lvl, '0);

        // Reset while in the long/repeat phase, button held throughout.
        btn_in[0] = 1'b1;
        wait_bit(0, 2, 200, at);
        check_rng("pre_reset_long", at, 0, 1 << 30);
        run(25);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_level", lvl, '0);
        check("rst_pulses", rise | fall | lng | rep, '0);
        run(4);
        rst_n = 1'b1;
        t0 = cyc;
        wait_bit(0, 0, 40, at);
        check_rng("post_reset_rise", at - t0, 22, 32);
        wait_bit(0, 2, 150, at2);
        check_rng("post_reset_long", at2 - at, 100, 100);
        btn_in = '0;
        run(60);

        // All channels together, then channel 2 alone.
        btn_in = 3'b111;
        wait_bit(0, 0, 40, at);
        check("simul_rise", rise, 3'b111);
        run(20);
        btn_in = 3'b011;
        wait_bit(2, 1, 40, at);
        check("single_fall", fall, 3'b100);
        btn_in = '0;
        run(60);

        // Random dwell times: short bursts bounce, long ones hold.
        for (int c = 0; c < N; c++) dwell[c] = $urandom_range(1, 40);
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) begin
                dwell[c]--;
                if (dwell[c] <= 0) begin
                    btn_in[c] = ~btn_in[c];
                    if ($urandom_range(0, 1) == 0)
                        dwell[c] = $urandom_range(1, 8);
                    else
                        dwell[c] = $urandom_range(20, 260);
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
